// File: rtl/gbar_pkg.sv
// Shared types and width helpers for the global barrier responder.
// Optional GBAR_PERF_EN build adds release/wait-cycle performance counters.
package gbar_pkg;

    localparam int PERF_W = 44;

    function automatic int id_width(input int num_barriers);
        return (num_barriers > 1) ? $clog2(num_barriers) : 1;
    endfunction

    function automatic int cid_width(input int num_cores);
        return (num_cores > 1) ? $clog2(num_cores) : 1;
    endfunction

    typedef enum logic {
        GBAR_IDLE    = 1'b0,
        GBAR_COLLECT = 1'b1
    } gbar_state_e;

    localparam int DEF_ID_W  = id_width(4);
    localparam int DEF_CID_W = cid_width(4);

    typedef struct packed {
        logic [DEF_ID_W-1:0]  id;
        logic [DEF_CID_W-1:0] size_m1;
        logic [DEF_CID_W-1:0] core_id;
    } gbar_req_t;

endpackage

// File: rtl/gbar_entry.sv
// One barrier ID: collects core arrivals and strobes rel (combinational) on
// the arrival that completes the barrier; state is exposed for debug.
module gbar_entry
    import gbar_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int CID_W     = cid_width(NUM_CORES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arrive,
    input  logic [CID_W-1:0] core_id,
    input  logic [CID_W-1:0] size_m1,
    output logic             rel,
    output logic             pending_next,
    output gbar_state_e      state
);

    gbar_state_e          state_d;
    logic [NUM_CORES-1:0] mask_q;
    logic [CID_W:0]       count_q;
    logic [CID_W-1:0]     size_q;

    logic [NUM_CORES-1:0] core_bit;
    logic                 dup;
    logic [CID_W:0]       count_inc;
    logic                 complete;

    assign core_bit  = NUM_CORES'(1) << core_id;
    assign dup       = |(mask_q & core_bit);
    assign count_inc = count_q + (CID_W+1)'(1);
    // Only the first arrival's size counts; later sizes are never compared.
    assign complete  = (count_inc == ({1'b0, size_q} + (CID_W+1)'(1)));

    always_ff @(posedge clk) begin
        if (reset) state <= GBAR_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            GBAR_IDLE:    if (arrive && (size_m1 != '0))     state_d = GBAR_COLLECT;
            GBAR_COLLECT: if (arrive && !dup && complete)    state_d = GBAR_IDLE;
            default:                                         state_d = GBAR_IDLE;
        endcase
    end

    always_comb begin
        rel = 1'b0;
        if (arrive) begin
            if (state == GBAR_IDLE) rel = (size_m1 == '0);
            else                    rel = !dup && complete;
        end
        pending_next = (state_d == GBAR_COLLECT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q  <= '0;
            count_q <= '0;
            size_q  <= '0;
        end else if (arrive) begin
            if (state == GBAR_IDLE) begin
                if (size_m1 != '0) begin
                    mask_q  <= core_bit;
                    count_q <= (CID_W+1)'(1);
                    size_q  <= size_m1;
                end
            end else if (!dup) begin
                if (complete) begin
                    mask_q  <= '0;
                    count_q <= '0;
                end else begin
                    mask_q  <= mask_q | core_bit;
                    count_q <= count_inc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && arrive && (state == GBAR_COLLECT)) begin
            assert (!dup) else $warning("gbar_entry: duplicate arrival from core %0d", core_id);
            assert (size_m1 == size_q) else $warning("gbar_entry: size_m1 %0d differs from latched %0d", size_m1, size_q);
        end
    end

endmodule

// File: rtl/gbar_unit.sv
// Global barrier responder: routes arrivals to per-ID entries and broadcasts
// a registered one-cycle release. GBAR_PERF_EN adds perf_releases/perf_wait_cycles.
module gbar_unit
    import gbar_pkg::*;
#(
    parameter int NUM_BARRIERS = 4,
    parameter int NUM_CORES    = 4,
    parameter int ID_W         = id_width(NUM_BARRIERS),
    parameter int CID_W        = cid_width(NUM_CORES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [ID_W-1:0]  req_id,
    input  logic [CID_W-1:0] req_size_m1,
    input  logic [CID_W-1:0] req_core_id,
    output logic             req_ready,
    output logic             rsp_valid,
    output logic [ID_W-1:0]  rsp_id,
`ifdef GBAR_PERF_EN
    output logic [PERF_W-1:0] perf_releases,
    output logic [PERF_W-1:0] perf_wait_cycles,
`endif
    output logic             busy
);

    // Handshake: a request is taken on any cycle with req_valid && req_ready;
    // req_ready is high whenever reset is low. rsp_valid is a pulse with no
    // backpressure, so the receiver must capture it in that cycle.
    logic                    fire;
    logic                    id_ok;
    logic                    core_ok;
    logic [NUM_BARRIERS-1:0] arrive;
    logic [NUM_BARRIERS-1:0] rel_vec;
    logic [NUM_BARRIERS-1:0] pend_next_vec;
    logic [NUM_BARRIERS-1:0] collect_now;
    gbar_state_e             state_vec [NUM_BARRIERS];

    assign req_ready = !reset;
    assign fire      = req_valid && req_ready;
    assign id_ok     = (32'(req_id) < NUM_BARRIERS);
    assign core_ok   = (32'(req_core_id) < NUM_CORES);

    for (genvar i = 0; i < NUM_BARRIERS; i++) begin : g_entry
        assign arrive[i]      = fire && id_ok && core_ok && (req_id == ID_W'(i));
        assign collect_now[i] = (state_vec[i] == GBAR_COLLECT);

        gbar_entry #(
            .NUM_CORES (NUM_CORES),
            .CID_W     (CID_W)
        ) u_entry (
            .clk          (clk),
            .reset        (reset),
            .arrive       (arrive[i]),
            .core_id      (req_core_id),
            .size_m1      (req_size_m1),
            .rel          (rel_vec[i]),
            .pending_next (pend_next_vec[i]),
            .state        (state_vec[i])
        );
    end

    // At most one arrival per cycle, so at most one release; req_id names it.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            busy      <= 1'b0;
        end else begin
            rsp_valid <= |rel_vec;
            rsp_id    <= (|rel_vec) ? req_id : '0;
            busy      <= |pend_next_vec;
        end
    end

`ifdef GBAR_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_releases    <= '0;
            perf_wait_cycles <= '0;
        end else begin
            if (rsp_valid && (perf_releases != '1))    perf_releases    <= perf_releases + 1'b1;
            if (busy && (perf_wait_cycles != '1))      perf_wait_cycles <= perf_wait_cycles + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (busy == |collect_now) else $error("gbar_unit: busy out of step with entry states");
            if (req_valid) begin
                assert (id_ok && core_ok) else $error("gbar_unit: illegal req_id %0d or req_core_id %0d", req_id, req_core_id);
            end
        end
    end

endmodule
